roe_prog: RTL and testbench



---
 rtl/roe_pkg.sv | 55 +++++
 rtl/roe_dmem.sv | 24 ++
 rtl/roe_regfile.sv | 30 +++
 rtl/roe_prog.sv | 172 +++++++++++++++++
 tb/tb_roe_prog.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/roe_pkg.sv
// Shared types and constants for the R.O.E. 8-bit load/store core.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package roe_pkg;

  localparam int DW       = 8;
  localparam int RF_DEPTH = 8;
  localparam int DM_DEPTH = 256;
  localparam int IM_DEPTH = 256;
  localparam int IW       = 12;
  localparam int RFAW     = $clog2(RF_DEPTH);
  localparam int DMAW     = $clog2(DM_DEPTH);
  localparam int PCW      = $clog2(IM_DEPTH);

  // Instruction word field positions
  localparam int OP_MSB  = 11;
  localparam int OP_LSB  = 8;
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 6;
  localparam int RS_MSB  = 5;
  localparam int RS_LSB  = 4;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_HALT  = 4'd0,
    OP_SLB   = 4'd1,
    OP_ADDI  = 4'd2,
    OP_SUBI  = 4'd3,
    OP_SLI   = 4'd4,
    OP_SRI   = 4'd5,
    OP_REDEF = 4'd6,
    OP_LD    = 4'd7,
    OP_SW    = 4'd8,
    OP_SLT   = 4'd9,
    OP_XOR   = 4'd10,
    OP_AND   = 4'd11,
    OP_OR    = 4'd12,
    OP_BNEZ  = 4'd13,
    OP_NOP0  = 4'd14,
    OP_NOP1  = 4'd15
  } opcode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Assemble one instruction word from its fields
  function automatic logic [IW-1:0] enc(input opcode_e op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [3:0] imm);
    return {op, rd, rs, imm};
  endfunction

endpackage

// File: rtl/roe_dmem.sv
// Byte-wide data memory, DM_DEPTH entries, shared address for read and write.
// Latency: read same cycle, write visible the cycle after we_i.
// Backpressure: none; contents are never reset.
module roe_dmem
  import roe_pkg::*;
(
  input  logic            clk,
  input  logic            we_i,
  input  logic [DMAW-1:0] addr_i,
  input  logic [DW-1:0]   wdata_i,
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0] core [0:DM_DEPTH-1];

  // Synchronous write
  always_ff @(posedge clk) begin
    if (we_i) core[addr_i] <= wdata_i;
  end

  // Asynchronous read
  always_comb rdata_o = core[addr_i];

endmodule

// File: rtl/roe_regfile.sv
// Windowed-core register file: 8 x DW, two combinational read ports, one write port.
// Latency: reads same cycle, write visible the cycle after we_i.
// Backpressure: none; a write is accepted every cycle we_i is high. Contents survive reset.
module roe_regfile
  import roe_pkg::*;
(
  input  logic            clk,
  input  logic            we_i,
  input  logic [RFAW-1:0] waddr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [RFAW-1:0] raddr_a_i,
  input  logic [RFAW-1:0] raddr_b_i,
  output logic [DW-1:0]   rdata_a_o,
  output logic [DW-1:0]   rdata_b_o
);

  logic [DW-1:0] RF [0:RF_DEPTH-1];

  // Single synchronous write port, deliberately unreset so host preloads persist
  always_ff @(posedge clk) begin
    if (we_i) RF[waddr_i] <= wdata_i;
  end

  // Two asynchronous read ports
  always_comb begin
    rdata_a_o = RF[raddr_a_i];
    rdata_b_o = RF[raddr_b_i];
  end

endmodule

// File: rtl/roe_prog.sv
// R.O.E. core top: ROM, PC, run-control FSM, decoder/ALU, register file and data memory.
// Latency: one instruction per cycle after req; ack pulses in the cycle the halt executes.
// Backpressure: req is only honoured in IDLE; it is ignored during a run and its ack cycle.
module roe_prog
  import roe_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic ack
);

  state_e          state_q, state_d;
  logic [PCW-1:0]  pc_q, pc_d;
  logic [RFAW-1:0] base_q, base_d;

  logic [IW-1:0]   instr;
  opcode_e         op;
  logic [1:0]      rd_f, rs_f;
  logic [3:0]      imm_f;
  logic            is_rrr;

  logic [RFAW-1:0] ra_idx, rb_idx, wr_idx;
  logic [DW-1:0]   ra_dat, rb_dat, dm_rdat;
  logic            rf_we, dm_we;
  logic [DW-1:0]   rf_wdat;

  // Fixed program image; every unlisted address holds halt
  function automatic logic [IW-1:0] rom_word(input logic [PCW-1:0] a);
    case (a)
      8'd0:    return enc(OP_SLB,   2'd0, 2'd0, 4'd1);
      8'd2:    return enc(OP_ADDI,  2'd0, 2'd0, 4'd8);
      8'd4:    return enc(OP_SUBI,  2'd0, 2'd0, 4'd7);
      8'd6:    return enc(OP_SLI,   2'd0, 2'd0, 4'd2);
      8'd8:    return enc(OP_SRI,   2'd0, 2'd0, 4'd1);
      8'd10:   return enc(OP_REDEF, 2'd0, 2'd0, 4'd4);
      8'd11:   return enc(OP_ADDI,  2'd0, 2'd0, 4'd2);
      8'd12:   return enc(OP_REDEF, 2'd0, 2'd0, 4'd0);
      8'd14:   return enc(OP_LD,    2'd1, 2'd0, 4'd0);
      8'd16:   return enc(OP_SW,    2'd1, 2'd0, 4'd0);
      8'd18:   return enc(OP_SLT,   2'd2, 2'd1, 4'd0);
      8'd20:   return enc(OP_XOR,   2'd2, 2'd1, 4'd0);
      8'd22:   return enc(OP_AND,   2'd2, 2'd1, 4'd0);
      8'd24:   return enc(OP_OR,    2'd2, 2'd1, 4'd0);
      default: return enc(OP_HALT,  2'd0, 2'd0, 4'd0);
    endcase
  endfunction

  // Fetch/decode and window-relative register index translation
  always_comb begin
    instr  = rom_word(pc_q);
    op     = opcode_e'(instr[OP_MSB:OP_LSB]);
    rd_f   = instr[RD_MSB:RD_LSB];
    rs_f   = instr[RS_MSB:RS_LSB];
    imm_f  = instr[IMM_MSB:IMM_LSB];
    is_rrr = (op == OP_SLT) || (op == OP_XOR) || (op == OP_AND) || (op == OP_OR);
    // Port A carries rt for three-register ops, rd otherwise; port B always rs
    ra_idx = base_q + {1'b0, (is_rrr ? imm_f[1:0] : rd_f)};
    rb_idx = base_q + {1'b0, rs_f};
    wr_idx = base_q + {1'b0, rd_f};
  end

  roe_regfile register_file (
    .clk       (clk),
    .we_i      (rf_we),
    .waddr_i   (wr_idx),
    .wdata_i   (rf_wdat),
    .raddr_a_i (ra_idx),
    .raddr_b_i (rb_idx),
    .rdata_a_o (ra_dat),
    .rdata_b_o (rb_dat)
  );

  roe_dmem dm1 (
    .clk     (clk),
    .we_i    (dm_we),
    .addr_i  (rb_dat),
    .wdata_i (ra_dat),
    .rdata_o (dm_rdat)
  );

  // Next-state, execute and ack generation; reset suppresses all side effects
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    base_d  = base_q;
    rf_we   = 1'b0;
    rf_wdat = '0;
    dm_we   = 1'b0;
    ack     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) state_d = ST_RUN;
      end
      ST_RUN: begin
        pc_d = pc_q + PCW'(1);
        case (op)
          OP_HALT: begin
            ack     = 1'b1;
            state_d = ST_IDLE;
          end
          OP_SLB: begin
            rf_we   = 1'b1;
            rf_wdat = {ra_dat[DW-1:4], imm_f};
          end
          OP_ADDI: begin
            rf_we   = 1'b1;
            rf_wdat = ra_dat + DW'(imm_f);
          end
          OP_SUBI: begin
            rf_we   = 1'b1;
            rf_wdat = ra_dat - DW'(imm_f);
          end
          OP_SLI: begin
            rf_we   = 1'b1;
            rf_wdat = ra_dat << imm_f;
          end
          OP_SRI: begin
            rf_we   = 1'b1;
            rf_wdat = ra_dat >> imm_f;
          end
          OP_REDEF: base_d = imm_f[RFAW-1:0];
          OP_LD: begin
            rf_we   = 1'b1;
            rf_wdat = dm_rdat;
          end
          OP_SW:   dm_we = 1'b1;
          OP_SLT: begin
            rf_we   = 1'b1;
            rf_wdat = (ra_dat < rb_dat) ? DW'(1) : DW'(0);
          end
          OP_XOR: begin
            rf_we   = 1'b1;
            rf_wdat = rb_dat ^ ra_dat;
          end
          OP_AND: begin
            rf_we   = 1'b1;
            rf_wdat = rb_dat & ra_dat;
          end
          OP_OR: begin
            rf_we   = 1'b1;
            rf_wdat = rb_dat | ra_dat;
          end
          OP_BNEZ: begin
            if (ra_dat != '0) pc_d = pc_q + {{(PCW-4){imm_f[3]}}, imm_f};
          end
          default: ;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
    if (reset) begin
      rf_we = 1'b0;
      dm_we = 1'b0;
      ack   = 1'b0;
    end
  end

  // Architectural state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      base_q  <= base_d;
    end
  end

endmodule

// File: tb/tb_roe_prog.sv
// Self-checking bench for roe_prog: directed table, randomized passes against a model, protocol cases.
// Latency: n/a.
// Backpressure: n/a.
module tb_roe_prog;

  logic clk;
  logic reset;
  logic req;
  logic ack;

  int n_checks;
  int n_fail;

  typedef struct {
    int         seg;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t dir_tab[12];

  roe_prog dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .ack   (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Program segment s begins at this ROM address; s=12 is the first free halt.
  function automatic int seg_start(input int s);
    if (s <= 5) return 2 * s;
    return 14 + 2 * (s - 6);
  endfunction

  // Expected result of segment s given operands a (p0, or rs/data) and b (rt/address)
  function automatic int model(input int s, input int a, input int b);
    case (s)
      0:  return (a / 16) * 16 + 1;
      1:  return (a + 8) % 256;
      2:  return (a + 256 - 7) % 256;
      3:  return (a * 4) % 256;
      4:  return a / 2;
      5:  return (a + 2) % 256;
      6:  return a;
      7:  return a;
      8:  return (b < a) ? 1 : 0;
      9:  return a ^ b;
      10: return a & b;
      11: return a | b;
      default: return 0;
    endcase
  endfunction

  // Pulse req for 'hold' cycles, count ack pulses over a fixed window, then check PC
  task automatic run_req(input int hold, input int exp_pc, input string tag);
    int acks;
    acks = 0;
    req  = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == hold - 1) req = 1'b0;
      if (ack) acks++;
    end
    check({tag, "_ack_count"}, acks, 1);
    check({tag, "_pc"}, int'(dut.pc_q), exp_pc);
  endtask

  task automatic apply_vec(input vec_t v, input bit preload, input string tag);
    @(negedge clk);
    check({tag, "_pc_start"}, int'(dut.pc_q), seg_start(v.seg));
    if (preload) begin
      case (v.seg)
        5: begin
          dut.register_file.RF[4] = v.a;
          dut.register_file.RF[0] = v.b;
        end
        6: begin
          dut.dm1.core[v.b]       = v.a;
          dut.register_file.RF[0] = v.b;
        end
        7, 8, 9, 10, 11: begin
          dut.register_file.RF[0] = v.b;
          dut.register_file.RF[1] = v.a;
        end
        default: dut.register_file.RF[0] = v.a;
      endcase
    end
    run_req(1, seg_start(v.seg + 1), tag);
    case (v.seg)
      5: begin
        check({tag, "_rf4"}, int'(dut.register_file.RF[4]), int'(v.exp));
        check({tag, "_rf0_kept"}, int'(dut.register_file.RF[0]), int'(v.b));
        check({tag, "_base"}, int'(dut.base_q), 0);
      end
      6:  check({tag, "_rf1"}, int'(dut.register_file.RF[1]), int'(v.exp));
      7:  check({tag, "_core"}, int'(dut.dm1.core[v.b]), int'(v.exp));
      8, 9, 10, 11: check({tag, "_rf2"}, int'(dut.register_file.RF[2]), int'(v.exp));
      default: check({tag, "_rf0"}, int'(dut.register_file.RF[0]), int'(v.exp));
    endcase
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   acks;

    n_checks = 0;
    n_fail   = 0;
    req      = 1'b0;
    reset    = 1'b1;

    dir_tab[0]  = '{0,  8'hAF, 8'h00, 8'hA1};
    dir_tab[1]  = '{1,  8'd100, 8'h00, 8'd108};
    dir_tab[2]  = '{2,  8'd100, 8'h00, 8'd93};
    dir_tab[3]  = '{3,  8'h02, 8'h00, 8'h08};
    dir_tab[4]  = '{4,  8'h10, 8'h00, 8'h08};
    dir_tab[5]  = '{5,  8'd99, 8'h37, 8'd101};
    dir_tab[6]  = '{6,  8'hAD, 8'h00, 8'hAD};
    dir_tab[7]  = '{7,  8'hAA, 8'h01, 8'hAA};
    dir_tab[8]  = '{8,  8'h05, 8'h01, 8'h01};
    dir_tab[9]  = '{9,  8'h00, 8'h01, 8'h01};
    dir_tab[10] = '{10, 8'h00, 8'h01, 8'h00};
    dir_tab[11] = '{11, 8'h00, 8'h01, 8'h01};

    // Preload while reset is held; req during reset must not start a run
    @(negedge clk);
    dut.register_file.RF[0] = 8'hAF;
    req = 1'b1;
    @(negedge clk);
    check("reset_ack", int'(ack), 0);
    @(negedge clk);
    req = 1'b0;
    check("reset_pc", int'(dut.pc_q), 0);
    check("reset_base", int'(dut.base_q), 0);
    reset = 1'b0;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("reset_req_ignored_ack", acks, 0);
    check("reset_req_ignored_pc", int'(dut.pc_q), 0);

    // Directed table through the whole program
    for (int i = 0; i < 12; i++)
      apply_vec(dir_tab[i], !(i == 0), $sformatf("dir%0d", i));

    // req held two cycles on a single-halt segment: one run, one ack
    run_req(2, 27, "hold2");
    repeat (3) @(negedge clk);
    check("hold2_pc_stays", int'(dut.pc_q), 27);

    // Randomized passes, each restarting the program via reset
    for (int p = 0; p < 3; p++) begin
      pulse_reset();
      check($sformatf("rnd%0d_pc_after_reset", p), int'(dut.pc_q), 0);
      for (int s = 0; s < 12; s++) begin
        v.seg = s;
        v.a   = 8'($urandom);
        v.b   = 8'($urandom);
        v.exp = 8'(model(s, int'(v.a), int'(v.b)));
        apply_vec(v, 1'b1, $sformatf("rnd%0d_seg%0d", p, s));
      end
    end

    // Reset in the middle of a run: abort, no ack, PC back to 0, RF retained
    pulse_reset();
    @(negedge clk);
    dut.register_file.RF[0] = 8'h55;
    req = 1'b1;
    @(negedge clk);
    req   = 1'b0;
    reset = 1'b1;
    check("midrst_ack_low", int'(ack), 0);
    @(negedge clk);
    check("midrst_ack_low2", int'(ack), 0);
    check("midrst_pc", int'(dut.pc_q), 0);
    check("midrst_rf_kept", int'(dut.register_file.RF[0]), 8'h55);
    reset = 1'b0;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("midrst_idle_no_ack", acks, 0);
    run_req(1, 2, "after_midrst");
    check("after_midrst_rf0", int'(dut.register_file.RF[0]), 8'h51);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
